// File: rtl/srl_fifo_pkg.sv
// Shared constants and read-address helper for the SRL32-based 64-deep FIFO.
package srl_fifo_pkg;

   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;
   localparam int CNT_W  = 7;

   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   // Head of the shift chain sits at occupancy-1; an empty FIFO points at entry 0.
   function automatic logic [ADDR_W-1:0] rd_addr(input logic [CNT_W-1:0] cnt);
      if (cnt == '0)
         return '0;
      else
         return ADDR_W'(cnt - CNT_W'(1));
   endfunction

endpackage

// File: rtl/srl64_bit.sv
// One FIFO bit column: two cascaded 32-entry shift registers (SRLC32E style)
// with the upper/lower halves selected by addr[5] (MUXF7_L style).
// Storage has no reset; it powers up to zero like SRL hardware.
module srl64_bit
   import srl_fifo_pkg::*;
(
   input  logic              clk,
   input  logic              ce,
   input  logic              d,
   input  logic [ADDR_W-1:0] addr,
   output logic              q
);

   logic [31:0] lo = '0;
   logic [31:0] hi = '0;

   // Shift both halves on an accepted write; lower Q31 cascades into upper D.
   always_ff @(posedge clk) begin
      if (ce) begin
         lo <= {lo[30:0], d};
         hi <= {hi[30:0], lo[31]};
      end
   end

   assign q = addr[5] ? hi[addr[4:0]] : lo[addr[4:0]];

endmodule

// File: rtl/srl_fifo64.sv
// 64-deep first-word-fall-through FIFO on SRL32 columns.
// Optional build macro SRL_FIFO_OREG_EN adds a registered output stage
// (capacity 65, write-to-valid latency 2). Default: combinational DOUT.
module srl_fifo64
   import srl_fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int AFULL_LVL = 60
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] DIN,
   input  logic             WR_EN,
   output logic             WR_RDY,
   output logic [WIDTH-1:0] DOUT,
   output logic             VALID_O,
   input  logic             RD_EN,
   output logic [CNT_W-1:0] COUNT,
   output logic             AFULL
);

   localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);

   logic [CNT_W-1:0]  cnt_p0;
   logic [ADDR_W-1:0] addr;
   logic [WIDTH-1:0]  head;
   logic              srl_vld;
   logic              wr_acc;
   logic              pop;

   assign WR_RDY  = cnt_p0 < DEPTH_CNT;
   assign srl_vld = cnt_p0 != '0;
   assign addr    = rd_addr(cnt_p0);
   assign wr_acc  = WR_EN & WR_RDY & ~RST;

   for (genvar i = 0; i < WIDTH; i++) begin : g_col
      srl64_bit u_col (
         .clk  (CLK),
         .ce   (wr_acc),
         .d    (DIN[i]),
         .addr (addr),
         .q    (head[i])
      );
   end

   // --- stage p0: SRL occupancy; a write and a pop together leave it unchanged
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_p0 <= '0;
      end else begin
         case ({wr_acc, pop})
            2'b10:   cnt_p0 <= cnt_p0 + CNT_W'(1);
            2'b01:   cnt_p0 <= cnt_p0 - CNT_W'(1);
            default: cnt_p0 <= cnt_p0;
         endcase
      end
   end

`ifdef SRL_FIFO_OREG_EN
   logic             vld_p1;
   logic [WIDTH-1:0] dout_p1;

   // SRL head moves into the output flop whenever the flop is empty or being read.
   assign pop = srl_vld & (~vld_p1 | RD_EN);

   // --- stage p1: registered output word and its valid flag
   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_p1  <= 1'b0;
         dout_p1 <= '0;
      end else if (pop) begin
         vld_p1  <= 1'b1;
         dout_p1 <= head;
      end else if (RD_EN) begin
         vld_p1  <= 1'b0;
      end
   end

   assign VALID_O = vld_p1;
   assign DOUT    = dout_p1;
   assign COUNT   = cnt_p0 + CNT_W'(vld_p1);
`else
   assign pop     = RD_EN & srl_vld;
   assign VALID_O = srl_vld;
   assign DOUT    = head;
   assign COUNT   = cnt_p0;
`endif

   assign AFULL = COUNT >= AFULL_CNT;

endmodule

// File: tb/tb_srl_fifo64.sv
// Scoreboard bench for srl_fifo64 (default build, combinational DOUT).
module tb_srl_fifo64;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] DIN;
   logic       WR_EN;
   logic       WR_RDY;
   logic [7:0] DOUT;
   logic       VALID_O;
   logic       RD_EN;
   logic [6:0] COUNT;
   logic       AFULL;

   int         total = 0;
   int         bad   = 0;
   int         mcnt  = 0;
   logic [7:0] last_wr = 8'h00;
   logic [7:0] sb[$];

   srl_fifo64 #(.WIDTH(8), .AFULL_LVL(60)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .DIN     (DIN),
      .WR_EN   (WR_EN),
      .WR_RDY  (WR_RDY),
      .DOUT    (DOUT),
      .VALID_O (VALID_O),
      .RD_EN   (RD_EN),
      .COUNT   (COUNT),
      .AFULL   (AFULL)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state();
      chk("count",  64'(COUNT),   64'(mcnt));
      chk("valid",  64'(VALID_O), 64'(mcnt != 0));
      chk("wr_rdy", 64'(WR_RDY),  64'(mcnt < 64));
      chk("afull",  64'(AFULL),   64'(mcnt >= 60));
   endtask

   // One clock of stimulus; the expected word is queued when the model accepts it.
   task automatic step(input logic wr, input logic [7:0] d, input logic rd);
      logic wa, ra;
      wa = wr && (mcnt < 64);
      ra = rd && (mcnt > 0);
      WR_EN = wr;
      DIN   = d;
      RD_EN = rd;
      if (wa) begin
         sb.push_back(d);
         last_wr = d;
      end
      @(posedge CLK);
      #1;
      if (wa && !ra) mcnt++;
      else if (ra && !wa) mcnt--;
      check_state();
   endtask

   // Monitor: head must match the oldest queued word; a read pops it.
   always @(negedge CLK) begin
      if (!RST && VALID_O) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL head_underflow actual=valid_with_dout_%0h required=empty", DOUT);
         end else begin
            chk("dout_head", 64'(DOUT), 64'(sb[0]));
            if (RD_EN) void'(sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      RST = 1'b1; WR_EN = 1'b0; RD_EN = 1'b0; DIN = 8'h00;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      mcnt = 0;
      check_state();
      chk("dout_por", 64'(DOUT), 64'h0);

      // three writes, head stays on the first word
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h22, 1'b0);
      step(1'b1, 8'h33, 1'b0);
      chk("dout_first", 64'(DOUT), 64'h11);
      repeat (3) step(1'b0, 8'h00, 1'b1);

      // fill to 64, overflow attempt, then read+write at full
      for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0);
      step(1'b1, 8'hFF, 1'b0);
      step(1'b1, 8'hEE, 1'b1);
      chk("dout_adv", 64'(DOUT), 64'h01);
      for (int i = 0; i < 63; i++) step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);

      // steady read+write at occupancy 5
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h85 + i), 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);

      // almost-full threshold
      for (int i = 0; i < 59; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
      step(1'b1, 8'h7E, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 39; i++) step(1'b0, 8'h00, 1'b1);

      // reset at occupancy 20 with a competing write
      RST = 1'b1; WR_EN = 1'b1; DIN = 8'h5A; RD_EN = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b0; WR_EN = 1'b0;
      mcnt = 0;
      sb.delete();
      check_state();
      chk("dout_stale", 64'(DOUT), 64'(last_wr));
      step(1'b1, 8'hA5, 1'b0);
      chk("dout_a5", 64'(DOUT), 64'hA5);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      chk("sb_empty", 64'(sb.size()), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
